// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction-fetch queue: FIFO entry layout,
// request FSM states and the datapath width.
package ifetch_queue_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of the PC input, instruction-memory bus and decode handshake seen by the fetch queue.
// master is the fetch queue's view; slave is the surrounding pipeline/memory.
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            mispred;
  logic            stall_o;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] addr_o;
  logic [XLEN-1:0] instr_o;

  modport master (
    input  pc_i, pc_valid_i, mispred, imem_ack, imem_rdata, ready_i,
    output stall_o, imem_req, imem_addr, valid_o, addr_o, instr_o
  );

  modport slave (
    output pc_i, pc_valid_i, mispred, imem_ack, imem_rdata, ready_i,
    input  stall_o, imem_req, imem_addr, valid_o, addr_o, instr_o
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head entry is held in a register
// so the decode-facing outputs come straight from flops.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  fetch_entry_t  head_reg, head_next;
  logic          do_push, do_pop, empty_after_pop;

  always_comb begin
    do_pop          = pop && (count_reg != '0) && !flush;
    do_push         = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);
    empty_after_pop = (count_reg == CW'(do_pop));
    rd_ptr_next     = rd_ptr_reg + PW'(do_pop);
    wr_ptr_next     = wr_ptr_reg + PW'(do_push);
    count_next      = count_reg + CW'(do_push) - CW'(do_pop);
    head_next       = head_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (count_next != '0) begin
      // A push into an otherwise-empty queue bypasses the array straight into the head
      head_next = (do_push && empty_after_pop) ? push_data : mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head       = head_reg;
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: turns accepted PCs into instruction-memory reads and queues the
// {addr, instr} results for decode; a mispredict discards everything buffered or in flight.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [CW-1:0]   count;
  logic            inflight, credit, accept, push;
  fetch_entry_t    push_data, head;
  logic            head_valid;

  always_comb begin
    inflight = (state_reg != IDLE);
    // The outstanding read already owns a slot, so its ack can never find the queue full
    credit   = (32'(count) + 32'(inflight)) < DEPTH;
    accept   = bus.pc_valid_i && !bus.mispred && credit &&
               ((state_reg == IDLE) || ((state_reg == WAIT) && bus.imem_ack));
    push     = (state_reg == WAIT) && bus.imem_ack && !bus.mispred;

    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          addr_next  = bus.pc_i;
        end
      end
      WAIT: begin
        if (bus.mispred) begin
          state_next = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          if (accept) begin
            addr_next = bus.pc_i;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  assign push_data = '{addr: addr_reg, instr: bus.imem_rdata};

  ifetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.ready_i),
    .flush     (bus.mispred),
    .head      (head),
    .head_valid(head_valid),
    .count     (count)
  );

  assign bus.stall_o   = bus.pc_valid_i && !accept && !bus.mispred;
  assign bus.imem_req  = inflight;
  assign bus.imem_addr = addr_reg;
  assign bus.valid_o   = head_valid;
  assign bus.addr_o    = head.addr;
  assign bus.instr_o   = head.instr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: the driver queues expected {addr, instr} on each
// accepted PC, a monitor pops and compares on every decode handshake.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus_if ();

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.master)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int n_pops   = 0;
  int cyc      = 0;
  fetch_entry_t exp_q [$];
  int pop_cyc [$];

  // Memory: automatic fixed-latency responder, or manual drive for corner cases
  logic        mem_auto   = 1'b1;
  int          mem_lat    = 1;
  int          lat_cnt    = 0;
  logic        auto_ack   = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        man_ack    = 1'b0;
  logic [31:0] man_rdata  = '0;

  assign bus_if.imem_ack   = mem_auto ? auto_ack   : man_ack;
  assign bus_if.imem_rdata = mem_auto ? auto_rdata : man_rdata;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    auto_ack = 1'b0;
    if (rst && bus_if.imem_req) begin
      if (lat_cnt >= mem_lat - 1) begin
        auto_ack   = 1'b1;
        auto_rdata = instr_of(bus_if.imem_addr);
        lat_cnt    = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst && bus_if.valid_o && bus_if.ready_i && !bus_if.mispred) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_output: got addr %h instr %h, required no entry",
                 bus_if.addr_o, bus_if.instr_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_addr", bus_if.addr_o, e.addr);
        check("pop_instr", bus_if.instr_o, e.instr);
        n_pops++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic [31:0] pc, input int max_wait, output int stalls);
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!bus_if.stall_o) begin
        exp_q.push_back('{addr: pc, instr: instr_of(pc)});
        break;
      end
      stalls++;
      if (stalls >= max_wait) begin
        n_checks++;
        n_fails++;
        $display("FAIL accept_timeout: pc %h still stalled after %0d cycles, required acceptance", pc, stalls);
        break;
      end
      tick();
    end
  endtask

  task automatic issue(input logic [31:0] pc, output int stalls);
    tick();
    bus_if.pc_i       = pc;
    bus_if.pc_valid_i = 1'b1;
    wait_accept(pc, 20, stalls);
  endtask

  task automatic idle();
    tick();
    bus_if.pc_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int s;
    int total;
    int pops_before;

    bus_if.pc_i       = '0;
    bus_if.pc_valid_i = 1'b0;
    bus_if.mispred    = 1'b0;
    bus_if.ready_i    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", bus_if.valid_o, 0);
    check("rst_imem_req", bus_if.imem_req, 0);
    check("rst_stall_o", bus_if.stall_o, 0);
    check("rst_imem_addr", bus_if.imem_addr, 0);
    check("rst_addr_o", bus_if.addr_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: back-to-back fetch of 0,4,8 with a 1-cycle memory
    total = 0;
    pop_cyc.delete();
    issue(32'h0, s); total += s;
    issue(32'h4, s); total += s;
    issue(32'h8, s); total += s;
    idle();
    repeat (5) tick();
    check("t1_stall_cycles", total, 0);
    check("t1_drained", exp_q.size(), 0);
    check("t1_pop_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("t1_gap01", pop_cyc[1] - pop_cyc[0], 1);
      check("t1_gap12", pop_cyc[2] - pop_cyc[1], 1);
    end

    // 2: decode blocked; four entries fill the queue, fifth PC stalls
    bus_if.ready_i = 1'b0;
    total = 0;
    issue(32'h200, s); total += s;
    issue(32'h204, s); total += s;
    issue(32'h208, s); total += s;
    issue(32'h20C, s); total += s;
    check("t2_fill_stalls", total, 0);
    tick();
    bus_if.pc_i = 32'h210;
    @(negedge clk);
    check("t2_fifth_stall", bus_if.stall_o, 1);
    tick();
    @(negedge clk);
    check("t2_still_stall", bus_if.stall_o, 1);
    check("t2_valid_held", bus_if.valid_o, 1);
    check("t2_head_addr", bus_if.addr_o, 32'h200);
    tick();
    bus_if.ready_i = 1'b1;
    wait_accept(32'h210, 10, s);
    check("t2_release_stalls", s, 1);
    idle();
    repeat (8) tick();
    check("t2_drained", exp_q.size(), 0);
    check("t2_stall_dropped", bus_if.stall_o, 0);

    // 3: mispredict while waiting; the late ack must be discarded
    mem_auto = 1'b0;
    issue(32'h40, s);
    tick();
    bus_if.pc_valid_i = 1'b0;
    check("t3_req_wait", bus_if.imem_req, 1);
    check("t3_addr_wait", bus_if.imem_addr, 32'h40);
    bus_if.mispred = 1'b1;
    @(negedge clk);
    exp_q.delete();
    tick();
    bus_if.mispred    = 1'b0;
    bus_if.pc_i       = 32'h44;
    bus_if.pc_valid_i = 1'b1;
    @(negedge clk);
    check("t3_drop_stall", bus_if.stall_o, 1);
    check("t3_drop_req", bus_if.imem_req, 1);
    tick();
    bus_if.pc_valid_i = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 32'hDEADBEEF;
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    check("t3_valid_after_drop", bus_if.valid_o, 0);
    check("t3_req_after_drop", bus_if.imem_req, 0);
    tick();
    check("t3_valid_later", bus_if.valid_o, 0);
    mem_auto = 1'b1;
    issue(32'h100, s);
    idle();
    repeat (4) tick();
    check("t3_drained", exp_q.size(), 0);

    // 4: mispredict coincides with an ack while two entries are buffered
    bus_if.ready_i = 1'b0;
    issue(32'h80, s);
    issue(32'h84, s);
    idle();
    tick();
    mem_auto = 1'b0;
    issue(32'h88, s);
    tick();
    bus_if.pc_valid_i = 1'b0;
    bus_if.mispred    = 1'b1;
    man_ack           = 1'b1;
    man_rdata         = 32'h1234_5678;
    @(negedge clk);
    check("t4_valid_before", bus_if.valid_o, 1);
    exp_q.delete();
    tick();
    bus_if.mispred = 1'b0;
    man_ack        = 1'b0;
    @(negedge clk);
    check("t4_valid_flushed", bus_if.valid_o, 0);
    check("t4_req_idle", bus_if.imem_req, 0);
    bus_if.ready_i = 1'b1;
    repeat (3) tick();
    check("t4_valid_stays_0", bus_if.valid_o, 0);
    mem_auto = 1'b1;

    // 5: fill, then stream with simultaneous push/pop across pointer wrap
    pops_before    = n_pops;
    bus_if.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h300 + 32'(4 * i), s);
    tick();
    bus_if.pc_i = 32'h310;
    @(negedge clk);
    check("t5_full_stall", bus_if.stall_o, 1);
    tick();
    bus_if.ready_i = 1'b1;
    wait_accept(32'h310, 10, s);
    for (int i = 0; i < 6; i++) issue(32'h314 + 32'(4 * i), s);
    idle();
    repeat (8) tick();
    check("t5_drained", exp_q.size(), 0);
    check("t5_pop_count", n_pops - pops_before, 11);

    // 6: reset asserted while a read is outstanding
    bus_if.ready_i = 1'b0;
    mem_auto       = 1'b0;
    issue(32'h4F0, s);
    tick();
    bus_if.pc_valid_i = 1'b0;
    man_ack   = 1'b1;
    man_rdata = instr_of(32'h4F0);
    tick();
    man_ack = 1'b0;
    issue(32'h500, s);
    tick();
    bus_if.pc_valid_i = 1'b0;
    @(negedge clk);
    check("t6_req_before", bus_if.imem_req, 1);
    check("t6_valid_before", bus_if.valid_o, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_req_reset", bus_if.imem_req, 0);
    check("t6_valid_reset", bus_if.valid_o, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    man_ack   = 1'b1;
    man_rdata = 32'hDEADBEEF;
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    check("t6_late_ack_valid", bus_if.valid_o, 0);
    check("t6_late_ack_req", bus_if.imem_req, 0);
    mem_auto       = 1'b1;
    bus_if.ready_i = 1'b1;
    issue(32'h600, s);
    idle();
    repeat (4) tick();
    check("t6_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
